// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter: registered round-robin
// grant, ack/err routed only to the owner, watchdog ends hung cycles with err.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_sel,
    input  logic              m0_we,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_sel,
    input  logic              m1_we,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DW-1:0]     m_rdata,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_sel,
    output logic              s_we,
    output logic              s_cyc,
    output logic              s_stb,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic req0, req1;
    logic g_cyc, g_stb;
    logic ack_g, err_g;

    assign req0  = m0_cyc & m0_stb;
    assign req1  = m1_cyc & m1_stb;
    assign g_cyc = (grant_q == M_DATA) ? m1_cyc : m0_cyc;
    assign g_stb = (grant_q == M_DATA) ? m1_stb : m0_stb;

    assign m_rdata = s_rdata;

    // Owner's ack/err only; the other master never sees either.
    assign m0_ack = ack_g & (grant_q == M_INST);
    assign m0_err = err_g & (grant_q == M_INST);
    assign m1_ack = ack_g & (grant_q == M_DATA);
    assign m1_err = err_g & (grant_q == M_DATA);

    // State, grant, round-robin history and watchdog counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= M_INST;
            last_q  <= M_DATA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave-side mux on the registered grant; m0 lines idle through otherwise.
    always_comb begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_sel   = m0_sel;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        if (state_q == BUSY) begin
            if (grant_q == M_DATA) begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_sel   = m1_sel;
                s_we    = m1_we;
            end else begin
                s_we    = m0_we;
            end
            s_cyc = g_cyc;
            s_stb = g_cyc & g_stb;
        end
    end

    // Arbitration, completion/abort/timeout handling and counter next state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_g   = 1'b0;
        err_g   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    grant_d = ~last_q;
                    state_d = BUSY;
                end else if (req0) begin
                    grant_d = M_INST;
                    state_d = BUSY;
                end else if (req1) begin
                    grant_d = M_DATA;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Abort wins so a master that has left the bus never gets ack.
                if (!g_cyc) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (s_ack) begin
                    ack_g   = 1'b1;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_g   = 1'b1;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOVER: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_wb_arbiter2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m_rdata, s_rdata;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic          m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic          m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic          s_we, s_cyc, s_stb, s_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_err(m1_err),
        .m_rdata(m_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] flags();
        return {s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err};
    endfunction

    task automatic idle_inputs();
        m0_addr = '0; m0_wdata = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; s_ack = 1'b1;
        #2;
        n_cmp++;
        if (flags() !== 7'b0000000) begin
            n_fail++; $display("FAIL reset_flags: got %b want %b", flags(), 7'b0000000);
        end
        @(negedge clk);
        n_cmp++;
        if (flags() !== 7'b0000000) begin
            n_fail++; $display("FAIL reset_hold: got %b want %b", flags(), 7'b0000000);
        end
        s_ack = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (flags() !== 7'b1110000) begin
            n_fail++; $display("FAIL reset_first_grant: got %b want %b", flags(), 7'b1110000);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic [6:0] exp;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h10; m0_sel = '1;
        for (int c = 0; c <= 4; c++) begin
            s_ack   = (c == 4);
            s_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            exp = (c == 0) ? 7'b0000000 : {2'b11, 1'b0, (c == 4), 3'b000};
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL read_flags c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c > 0) begin
                n_cmp++;
                if (s_addr !== 32'h10) begin
                    n_fail++; $display("FAIL read_addr c=%0d: got %h want %h", c, s_addr, 32'h10);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (m_rdata !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL read_rdata: got %h want %h", m_rdata, 32'hDEADBEEF);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (flags() !== 7'b0000000) begin
            n_fail++; $display("FAIL read_after: got %b want %b", flags(), 7'b0000000);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp;
        int owner;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h200;
        s_ack = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            owner = ((c - 1) / 2) % 2;
            if (c % 2 == 0) exp = 7'b0000000;
            else exp = {3'b110, (owner == 0), 1'b0, (owner == 1), 1'b0};
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL tie_flags c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c % 2 == 1) begin
                n_cmp++;
                if (s_addr !== ((owner == 0) ? 32'h100 : 32'h200)) begin
                    n_fail++; $display("FAIL tie_addr c=%0d: got %h owner %0d", c, s_addr, owner);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_byte_write();
        logic [6:0] exp;
        do_reset();
        m0_addr = 32'h99; m0_wdata = 32'h11111111; m0_sel = 4'b1111; m0_we = 1'b1; m0_stb = 1'b1;
        m1_addr = 32'h24; m1_wdata = 32'h00AB0000; m1_sel = 4'b0100; m1_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            s_ack = (c == 2);
            @(negedge clk);
            exp = (c == 0) ? 7'b0000000 : {3'b111, 2'b00, (c == 2), 1'b0};
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL write_flags c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c > 0) begin
                n_cmp++;
                if ({s_addr, s_wdata, s_sel} !== {32'h24, 32'h00AB0000, 4'b0100}) begin
                    n_fail++;
                    $display("FAIL write_bus c=%0d: got %h/%h/%b want 24/00ab0000/0100", c, s_addr, s_wdata, s_sel);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [6:0] exp;
        do_reset();
        m0_addr = 32'h300; m1_addr = 32'h400;
        for (int c = 0; c <= 7; c++) begin
            m0_cyc = (c <= 4); m0_stb = (c <= 4);
            m1_cyc = (c >= 2); m1_stb = (c >= 2);
            s_ack  = (c >= 5);
            @(negedge clk);
            case (c)
                0, 5, 6: exp = 7'b0000000;
                4:       exp = 7'b1100100;
                7:       exp = 7'b1100010;
                default: exp = 7'b1100000;
            endcase
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL timeout_flags c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c == 7) begin
                n_cmp++;
                if (s_addr !== 32'h400) begin
                    n_fail++; $display("FAIL timeout_next_owner: got %h want %h", s_addr, 32'h400);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [6:0] exp;
        do_reset();
        m0_addr = 32'h500; m1_addr = 32'h600;
        for (int c = 0; c <= 4; c++) begin
            m1_cyc = (c <= 1); m1_stb = 1'b1;
            m0_cyc = (c >= 1); m0_stb = (c >= 1);
            s_ack  = (c == 4);
            @(negedge clk);
            case (c)
                1:       exp = 7'b1100000;
                4:       exp = 7'b1101000;
                default: exp = 7'b0000000;
            endcase
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL abort_flags c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c == 4) begin
                n_cmp++;
                if (s_addr !== 32'h500) begin
                    n_fail++; $display("FAIL abort_next_owner: got %h want %h", s_addr, 32'h500);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h700;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h800;
        for (int c = 0; c <= 3; c++) begin
            s_ack = (c <= 2);
            @(negedge clk);
            case (c)
                1:       exp = 7'b1101000;
                3:       exp = 7'b1100000;
                default: exp = 7'b0000000;
            endcase
            n_cmp++;
            if (flags() !== exp) begin
                n_fail++; $display("FAIL midrst_pre c=%0d: got %b want %b", c, flags(), exp);
            end
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        #2;
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        n_cmp++;
        if (flags() !== 7'b0000000) begin
            n_fail++; $display("FAIL midrst_immediate: got %b want %b", flags(), 7'b0000000);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (flags() !== 7'b1101000 || s_addr !== 32'h700) begin
            n_fail++; $display("FAIL midrst_tie_to_m0: got %b/%h want %b/%h", flags(), s_addr, 7'b1101000, 32'h700);
        end
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1, aw;
        logic [DW-1:0] d0, d1, dw, rd;
        logic [SW-1:0] s0, s1, sw;
        logic          w0, w1, ww;
        logic [6:0]    exp;
        int            pat, dly, win, last_win;
        do_reset();
        last_win = 1;
        for (int it = 0; it < 60; it++) begin
            pat = $urandom_range(1, 3);
            dly = $urandom_range(0, 2);
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
            s0 = SW'($urandom); s1 = SW'($urandom);
            w0 = 1'($urandom); w1 = 1'($urandom);
            m0_addr = a0; m0_wdata = d0; m0_sel = s0; m0_we = w0;
            m1_addr = a1; m1_wdata = d1; m1_sel = s1; m1_we = w1;
            m0_cyc = (pat != 2); m0_stb = (pat != 2);
            m1_cyc = (pat != 1); m1_stb = (pat != 1);
            s_ack = 1'b0;
            // Round robin: a tie goes to whoever did not finish the last transfer.
            if (pat == 3) win = 1 - last_win;
            else win = (pat == 1) ? 0 : 1;
            aw = (win == 0) ? a0 : a1;
            dw = (win == 0) ? d0 : d1;
            sw = (win == 0) ? s0 : s1;
            ww = (win == 0) ? w0 : w1;
            @(negedge clk);
            n_cmp++;
            if (flags() !== 7'b0000000) begin
                n_fail++; $display("FAIL rand_idle it=%0d: got %b want %b", it, flags(), 7'b0000000);
            end
            @(posedge clk); #1;
            for (int i = 0; i <= dly; i++) begin
                rd = $urandom;
                s_ack = (i == dly);
                s_rdata = rd;
                @(negedge clk);
                exp = {2'b11, ww, (i == dly) && (win == 0), 1'b0, (i == dly) && (win == 1), 1'b0};
                n_cmp++;
                if (flags() !== exp) begin
                    n_fail++; $display("FAIL rand_flags it=%0d i=%0d: got %b want %b", it, i, flags(), exp);
                end
                n_cmp++;
                if ({s_addr, s_wdata, s_sel} !== {aw, dw, sw}) begin
                    n_fail++;
                    $display("FAIL rand_bus it=%0d: got %h/%h/%h want %h/%h/%h", it, s_addr, s_wdata, s_sel, aw, dw, sw);
                end
                if (i == dly) begin
                    n_cmp++;
                    if (m_rdata !== rd) begin
                        n_fail++; $display("FAIL rand_rdata it=%0d: got %h want %h", it, m_rdata, rd);
                    end
                end
                @(posedge clk); #1;
            end
            last_win = win;
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            s_ack = 1'b0;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_byte_write();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
